// File: rtl/des_key_schedule_rev_if.sv
// Handshake bundle for the reverse-order DES key scheduler: key input channel,
// subkey output channel and the busy status flag.
interface des_key_schedule_rev_if;
    logic        key_valid;
    logic        key_ready;
    logic [1:64] key;
    logic        rk_valid;
    logic        rk_ready;
    logic [1:48] rk;
    logic [3:0]  rk_round;
    logic        rk_last;
    logic        busy;

    // Key source / subkey consumer side.
    modport master (
        output key_valid,
        output key,
        output rk_ready,
        input  key_ready,
        input  rk_valid,
        input  rk,
        input  rk_round,
        input  rk_last,
        input  busy
    );

    // Scheduler side.
    modport slave (
        input  key_valid,
        input  key,
        input  rk_ready,
        output key_ready,
        output rk_valid,
        output rk,
        output rk_round,
        output rk_last,
        output busy
    );
endinterface

// File: rtl/des_key_schedule_rev.sv
// DES decryption key scheduler: takes a 64-bit key, emits K16 down to K1, one
// subkey per valid/ready transfer. C/D start at PC-1(key), which equals C16/D16,
// and are rotated right between subkeys to walk the schedule backwards.
module des_key_schedule_rev (
    input logic                    clk,
    input logic                    rst,
    des_key_schedule_rev_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    // Permuted choice 1, FIPS 46-3 bit numbering (1 = MSB of key).
    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2 over the 56-bit {C, D} concatenation (1 = MSB).
    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    state_e      state_q, state_d;
    logic [0:27] c_q, c_d;
    logic [0:27] d_q, d_d;
    logic [3:0]  idx_q, idx_d;

    logic [0:27] pc1_c, pc1_d;
    logic [0:27] c_rot1, c_rot2, d_rot1, d_rot2;
    logic        one_shift;
    logic [1:56] cd;
    logic [1:48] pc2_out;

    // PC-1 split of the offered key into the C and D halves.
    always_comb begin
        pc1_c = '0;
        pc1_d = '0;
        for (int i = 0; i < 28; i++) begin
            pc1_c[i] = bus.key[PC1[i]];
            pc1_d[i] = bus.key[PC1[i + 28]];
        end
    end

    // Right rotations; one-position shifts undo rounds 16, 9 and 2 (idx 15, 8, 1).
    always_comb begin
        c_rot1    = {c_q[27], c_q[0:26]};
        c_rot2    = {c_q[26:27], c_q[0:25]};
        d_rot1    = {d_q[27], d_q[0:26]};
        d_rot2    = {d_q[26:27], d_q[0:25]};
        one_shift = (idx_q == 4'd15) || (idx_q == 4'd8) || (idx_q == 4'd1);
    end

    // PC-2 of the current C/D, presented as the subkey.
    always_comb begin
        cd      = {c_q, d_q};
        pc2_out = '0;
        for (int i = 0; i < 48; i++) begin
            pc2_out[i + 1] = cd[PC2[i]];
        end
    end

    // State, halves and round index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: load on key accept, step backwards on each subkey transfer.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (bus.key_valid) begin
                    c_d     = pc1_c;
                    d_d     = pc1_d;
                    idx_d   = 4'd15;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (bus.rk_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        c_d   = one_shift ? c_rot1 : c_rot2;
                        d_d   = one_shift ? d_rot1 : d_rot2;
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only.
    always_comb begin
        bus.key_ready = (state_q == StIdle);
        bus.rk_valid  = (state_q == StEmit);
        bus.busy      = (state_q == StEmit);
        bus.rk        = pc2_out;
        bus.rk_round  = idx_q;
        bus.rk_last   = (state_q == StEmit) && (idx_q == 4'd0);
    end

endmodule
